// File: rtl/counter_pkg.sv
// Shared types for the multimode counter block.
//   cnt_mode_e  : run mode selected on start (RSVD behaves as FREE)
//   cnt_state_e : control FSM state encoding
package counter_pkg;

    typedef enum logic [1:0] {
        FREE     = 2'b00,
        ONE_SHOT = 2'b01,
        PERIODIC = 2'b10,
        RSVD     = 2'b11
    } cnt_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } cnt_state_e;

endpackage

// File: rtl/cnt_prescaler.sv
// Advance-tick generator for multimode_counter.
// Only built when MULTIMODE_COUNTER_PRESCALER_EN is defined.
// Ports:
//   clk, rstn  : clock, async active-low reset
//   restart    : zeroes the phase counter (clear/start/load)
//   qual       : a qualifying cycle (RUN, en, no control event)
//   prescale   : tick once every prescale+1 qualifying cycles
//   tick       : advance permitted this cycle
`ifdef MULTIMODE_COUNTER_PRESCALER_EN
module cnt_prescaler #(
    parameter int PRESC_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   restart,
    input  logic                   qual,
    input  logic [PRESC_WIDTH-1:0] prescale,
    output logic                   tick
);

    logic [PRESC_WIDTH-1:0] presc_cnt_q;
    logic [PRESC_WIDTH-1:0] presc_cnt_d;

    // >= rather than == so a prescale lowered mid-run cannot strand the phase
    assign tick = qual && (presc_cnt_q >= prescale);

    always_comb begin
        presc_cnt_d = presc_cnt_q;
        if (restart) begin
            presc_cnt_d = '0;
        end else if (qual) begin
            presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) presc_cnt_q <= '0;
        else       presc_cnt_q <= presc_cnt_d;
    end

endmodule
`endif

// File: rtl/multimode_counter.sv
// Up/down counter with FREE (wrap), ONE_SHOT (saturate) and PERIODIC
// (auto-reload) modes, single-cycle match pulse, sticky overflow/underflow.
// Optional macro MULTIMODE_COUNTER_PRESCALER_EN adds PRESC_WIDTH and the
// prescale input; advances then happen every prescale+1 qualifying cycles.
// Ports:
//   clk, rstn                  : clock, async active-low reset
//   en                         : count enable
//   clear/load/stop/start      : control, priority clear>load>stop>start
//   load_val                   : load and auto-reload value
//   dir/step/mode/limit        : config, latched on start
//   count_val, match           : registered count and terminal pulse
//   overflow, underflow        : sticky FREE-mode carry/borrow
//   busy, done                 : FSM in RUN / DONE
//
// state | meaning
// IDLE  | stopped, count held
// RUN   | counting while en=1
// DONE  | ONE_SHOT reached its limit, count held
module multimode_counter
    import counter_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int STEP_WIDTH = 8
`ifdef MULTIMODE_COUNTER_PRESCALER_EN
    ,
    parameter int PRESC_WIDTH = 8
`endif
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  clear,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  dir,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic [1:0]            mode,
    input  logic [WIDTH-1:0]      limit,
`ifdef MULTIMODE_COUNTER_PRESCALER_EN
    input  logic [PRESC_WIDTH-1:0] prescale,
`endif
    output logic [WIDTH-1:0]      count_val,
    output logic                  match,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  busy,
    output logic                  done
);

    cnt_state_e            state_q, state_d;
    logic [WIDTH-1:0]      count_q, count_d;
    logic                  match_q, match_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  dir_q, dir_d;
    logic [STEP_WIDTH-1:0] step_q, step_d;
    cnt_mode_e             mode_q, mode_d;
    logic [WIDTH-1:0]      limit_q, limit_d;

    logic [WIDTH:0] step_ext, cnt_ext, lim_ext, nxt_up, nxt_dn, nxt;
    logic           term, free_mode, qual, tick, adv;

    assign qual = (state_q == RUN) && en && !clear && !load && !stop && !start;

`ifdef MULTIMODE_COUNTER_PRESCALER_EN
    cnt_prescaler #(.PRESC_WIDTH(PRESC_WIDTH)) u_presc (
        .clk      (clk),
        .rstn     (rstn),
        .restart  (clear | start | load),
        .qual     (qual),
        .prescale (prescale),
        .tick     (tick)
    );
`else
    assign tick = 1'b1;
`endif

    assign adv = qual && tick;

    always_comb begin
        step_ext  = {{(WIDTH + 1 - STEP_WIDTH){1'b0}}, step_q};
        cnt_ext   = {1'b0, count_q};
        lim_ext   = {1'b0, limit_q};
        nxt_up    = cnt_ext + step_ext;
        nxt_dn    = cnt_ext - step_ext;
        nxt       = dir_q ? nxt_dn : nxt_up;
        // Down compares before subtracting so it can never see a wrapped value
        term      = dir_q ? (cnt_ext <= lim_ext + step_ext) : (nxt_up >= lim_ext);
        free_mode = (mode_q == FREE) || (mode_q == RSVD);
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        match_d = 1'b0;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        dir_d   = dir_q;
        step_d  = step_q;
        mode_d  = mode_q;
        limit_d = limit_q;

        if (clear) begin
            count_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
            state_d = IDLE;
        end else if (load || stop || start) begin
            if (load) count_d = load_val;
            if (stop) begin
                state_d = IDLE;
            end else if (start) begin
                dir_d   = dir;
                step_d  = step;
                mode_d  = cnt_mode_e'(mode);
                limit_d = limit;
                state_d = RUN;
            end
        end else if (adv) begin
            if (free_mode) begin
                count_d = nxt[WIDTH-1:0];
                match_d = (nxt[WIDTH-1:0] == limit_q);
                if (dir_q) unf_d = unf_q | nxt[WIDTH];
                else       ovf_d = ovf_q | nxt[WIDTH];
            end else if (term) begin
                match_d = 1'b1;
                if (mode_q == ONE_SHOT) begin
                    count_d = limit_q;
                    state_d = DONE;
                end else begin
                    count_d = load_val;
                end
            end else begin
                count_d = nxt[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            count_q <= '0;
            match_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            dir_q   <= 1'b0;
            step_q  <= '0;
            mode_q  <= FREE;
            limit_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            match_q <= match_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            mode_q  <= mode_d;
            limit_q <= limit_d;
        end
    end

    assign count_val = count_q;
    assign match     = match_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_multimode_counter.sv
// Scoreboard bench for multimode_counter (WIDTH=8). Stimulus pushes the
// expected observation for each cycle; a monitor pops and compares after
// each clock edge or an explicit check event (async reset).
module tb_multimode_counter;

    typedef struct packed {
        logic [7:0] cnt;
        logic       m;
        logic       o;
        logic       u;
        logic       b;
        logic       d;
    } obs_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       en = 1'b0, clear = 1'b0, start = 1'b0, stop = 1'b0, load = 1'b0;
    logic [7:0] load_val = '0, step = '0, limit = '0;
    logic       dir = 1'b0;
    logic [1:0] mode = '0;
`ifdef MULTIMODE_COUNTER_PRESCALER_EN
    logic [7:0] prescale = '0;
`endif
    logic [7:0] count_val;
    logic       match, overflow, underflow, busy, done;

    obs_t  exp_q[$];
    string name_q[$];
    int    pass_cnt = 0;
    int    total_cnt = 0;
    event  chk_ev;

    multimode_counter #(.WIDTH(8), .STEP_WIDTH(8)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .en        (en),
        .clear     (clear),
        .start     (start),
        .stop      (stop),
        .load      (load),
        .load_val  (load_val),
        .dir       (dir),
        .step      (step),
        .mode      (mode),
        .limit     (limit),
`ifdef MULTIMODE_COUNTER_PRESCALER_EN
        .prescale  (prescale),
`endif
        .count_val (count_val),
        .match     (match),
        .overflow  (overflow),
        .underflow (underflow),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // monitor
    initial begin
        obs_t  e, a;
        string n;
        forever begin
            @(posedge clk or chk_ev);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                a = '{cnt: count_val, m: match, o: overflow, u: underflow, b: busy, d: done};
                total_cnt++;
                if (a === e) pass_cnt++;
                else $display("FAIL %s: got cnt=%h m=%b o=%b u=%b busy=%b done=%b, expected cnt=%h m=%b o=%b u=%b busy=%b done=%b",
                              n, a.cnt, a.m, a.o, a.u, a.b, a.d, e.cnt, e.m, e.o, e.u, e.b, e.d);
            end
        end
    end

    task automatic push_exp(input string nm, input logic [7:0] c,
                            input logic m, input logic o, input logic u,
                            input logic b, input logic d);
        exp_q.push_back('{cnt: c, m: m, o: o, u: u, b: b, d: d});
        name_q.push_back(nm);
    endtask

    // One clock with an expected post-edge observation; pulses drop afterwards.
    task automatic cyc(input string nm, input logic [7:0] c,
                       input logic m, input logic o, input logic u,
                       input logic b, input logic d);
        push_exp(nm, c, m, o, u, b, d);
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0; load = 1'b0; stop = 1'b0; start = 1'b0;
    endtask

    task automatic cfg(input logic [7:0] lv, input logic [7:0] lim,
                       input logic [7:0] st, input logic [1:0] md, input logic dr);
        load_val = lv; limit = lim; step = st; mode = md; dir = dr;
    endtask

    initial begin
        @(negedge clk);
        push_exp("reset", 8'h00, 0, 0, 0, 0, 0);
        -> chk_ev;
        #2 rstn = 1'b1;
        cyc("idle_after_reset", 8'h00, 0, 0, 0, 0, 0);

        // FREE up: FE + 3 wraps to 01 (== limit, so match)
        cfg(8'hFE, 8'h01, 8'd3, 2'b00, 1'b0);
        en = 1; load = 1; start = 1;
        cyc("free_up_loadstart", 8'hFE, 0, 0, 0, 1, 0);
        cyc("free_up_wrap", 8'h01, 1, 1, 0, 1, 0);
        cyc("free_up_next", 8'h04, 0, 1, 0, 1, 0);
        en = 0;
        cyc("free_en_low_hold", 8'h04, 0, 1, 0, 1, 0);
        stop = 1;
        cyc("free_stop", 8'h04, 0, 1, 0, 0, 0);
        clear = 1;
        cyc("free_clear", 8'h00, 0, 0, 0, 0, 0);

        // RSVD mode behaves as FREE; down borrow
        cfg(8'h01, 8'h80, 8'd2, 2'b11, 1'b1);
        en = 1; load = 1; start = 1;
        cyc("rsvd_down_loadstart", 8'h01, 0, 0, 0, 1, 0);
        cyc("rsvd_down_borrow", 8'hFF, 0, 0, 1, 1, 0);
        cyc("rsvd_down_next", 8'hFD, 0, 0, 1, 1, 0);
        clear = 1;
        cyc("rsvd_clear", 8'h00, 0, 0, 0, 0, 0);

        // ONE_SHOT up saturate at 10
        cfg(8'h00, 8'd10, 8'd4, 2'b01, 1'b0);
        load = 1; start = 1;
        cyc("os_loadstart", 8'h00, 0, 0, 0, 1, 0);
        cyc("os_4", 8'h04, 0, 0, 0, 1, 0);
        cyc("os_8", 8'h08, 0, 0, 0, 1, 0);
        cyc("os_sat", 8'h0A, 1, 0, 0, 0, 1);
        cyc("os_hold_done", 8'h0A, 0, 0, 0, 0, 1);
        start = 1;
        cyc("os_restart", 8'h0A, 0, 0, 0, 1, 0);
        cyc("os_at_limit_fires", 8'h0A, 1, 0, 0, 0, 1);
        stop = 1;
        cyc("os_stop_from_done", 8'h0A, 0, 0, 0, 0, 0);

        // PERIODIC down reload
        cfg(8'd9, 8'd2, 8'd3, 2'b10, 1'b1);
        load = 1; start = 1;
        cyc("per_loadstart", 8'h09, 0, 0, 0, 1, 0);
        cyc("per_6", 8'h06, 0, 0, 0, 1, 0);
        cyc("per_3", 8'h03, 0, 0, 0, 1, 0);
        cyc("per_reload", 8'h09, 1, 0, 0, 1, 0);
        cyc("per_6_again", 8'h06, 0, 0, 0, 1, 0);
        en = 0;
        cyc("per_en_low", 8'h06, 0, 0, 0, 1, 0);
        en = 1;

        // step=0 at limit fires every advance
        cfg(8'd2, 8'd2, 8'd0, 2'b10, 1'b0);
        load = 1; start = 1;
        cyc("step0_loadstart", 8'h02, 0, 0, 0, 1, 0);
        cyc("step0_fire1", 8'h02, 1, 0, 0, 1, 0);
        cyc("step0_fire2", 8'h02, 1, 0, 0, 1, 0);

        // priority
        cfg(8'h55, 8'h00, 8'd1, 2'b00, 1'b0);
        clear = 1; load = 1; start = 1;
        cyc("prio_clear_wins", 8'h00, 0, 0, 0, 0, 0);
        load_val = 8'h30; load = 1; start = 1;
        cyc("prio_load_start", 8'h30, 0, 0, 0, 1, 0);
        cyc("prio_adv", 8'h31, 0, 0, 0, 1, 0);
        load_val = 8'h70; load = 1;
        cyc("prio_load_in_run", 8'h70, 0, 0, 0, 1, 0);
        stop = 1; start = 1;
        cyc("prio_stop_over_start", 8'h70, 0, 0, 0, 0, 0);
        cyc("idle_en_hold", 8'h70, 0, 0, 0, 0, 0);

        // async reset mid-run
        start = 1;
        cyc("rst_pre_start", 8'h70, 0, 0, 0, 1, 0);
        cyc("rst_pre_adv", 8'h71, 0, 0, 0, 1, 0);
        #1 rstn = 1'b0;
        push_exp("async_reset", 8'h00, 0, 0, 0, 0, 0);
        -> chk_ev;
        #2 rstn = 1'b1;
        cyc("after_reset_idle", 8'h00, 0, 0, 0, 0, 0);

`ifdef MULTIMODE_COUNTER_PRESCALER_EN
        prescale = 8'd2;
        cfg(8'h00, 8'hFF, 8'd1, 2'b00, 1'b0);
        load = 1; start = 1;
        cyc("ps_loadstart", 8'h00, 0, 0, 0, 1, 0);
        cyc("ps_q1", 8'h00, 0, 0, 0, 1, 0);
        cyc("ps_q2", 8'h00, 0, 0, 0, 1, 0);
        cyc("ps_tick1", 8'h01, 0, 0, 0, 1, 0);
        cyc("ps_q4", 8'h01, 0, 0, 0, 1, 0);
        en = 0;
        for (int i = 0; i < 5; i++) cyc("ps_en_low", 8'h01, 0, 0, 0, 1, 0);
        en = 1;
        cyc("ps_q5", 8'h01, 0, 0, 0, 1, 0);
        cyc("ps_tick2", 8'h02, 0, 0, 0, 1, 0);
`endif

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            total_cnt++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
